// File: rtl/td4_pkg.sv
// TD4 shared definitions: opcode set, ALU mux select encodings and
// instruction-word field positions used by the control unit and decoder.
package td4_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A    = 4'b0000,  // ADD A,Im
    OP_MOV_AB   = 4'b0001,  // MOV A,B
    OP_IN_A     = 4'b0010,  // IN  A
    OP_MOV_A_IM = 4'b0011,  // MOV A,Im
    OP_MOV_BA   = 4'b0100,  // MOV B,A
    OP_ADD_B    = 4'b0101,  // ADD B,Im
    OP_IN_B     = 4'b0110,  // IN  B
    OP_MOV_B_IM = 4'b0111,  // MOV B,Im
    OP_OUT_B    = 4'b1001,  // OUT B
    OP_OUT_IM   = 4'b1011,  // OUT Im
    OP_JNC      = 4'b1110,  // JNC Im
    OP_JMP      = 4'b1111   // JMP Im
  } opcode_e;

  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_IN   = 2'b10,
    SEL_ZERO = 2'b11
  } sel_e;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned IM_MSB  = 3;
  localparam int unsigned IM_LSB  = 0;

endpackage

// File: rtl/td4_decoder.sv
// TD4 instruction decoder (purely combinational).
// Ports:
//   opcode   in  4  instruction opcode field
//   carry    in  1  registered carry flag (for JNC)
//   sel      out 2  ALU mux select
//   load_a   out 1  load strobe for register A
//   load_b   out 1  load strobe for register B
//   load_out out 1  load strobe for the OUT register
//   pc_load  out 1  jump taken: PC takes the immediate
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry,
  output logic [1:0] sel,
  output logic       load_a,
  output logic       load_b,
  output logic       load_out,
  output logic       pc_load
);

  always_comb begin
    sel      = SEL_ZERO;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_out = 1'b0;
    pc_load  = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD_A:    begin sel = SEL_A;    load_a   = 1'b1; end
      OP_MOV_AB:   begin sel = SEL_B;    load_a   = 1'b1; end
      OP_IN_A:     begin sel = SEL_IN;   load_a   = 1'b1; end
      OP_MOV_A_IM: begin sel = SEL_ZERO; load_a   = 1'b1; end
      OP_MOV_BA:   begin sel = SEL_A;    load_b   = 1'b1; end
      OP_ADD_B:    begin sel = SEL_B;    load_b   = 1'b1; end
      OP_IN_B:     begin sel = SEL_IN;   load_b   = 1'b1; end
      OP_MOV_B_IM: begin sel = SEL_ZERO; load_b   = 1'b1; end
      OP_OUT_B:    begin sel = SEL_B;    load_out = 1'b1; end
      OP_OUT_IM:   begin sel = SEL_ZERO; load_out = 1'b1; end
      OP_JNC:      begin sel = SEL_ZERO; pc_load  = ~carry; end
      OP_JMP:      begin sel = SEL_ZERO; pc_load  = 1'b1;   end
      default:     ;  // NOP
    endcase
  end

endmodule

// File: rtl/td4_control_unit.sv
// TD4 sequencing/decode stage: program counter, carry flag, halt detect,
// and decode of the ROM word into register load strobes and mux select.
// Ports:
//   CLK       in  1     system clock, rising edge
//   CLR       in  1     asynchronous active-low reset
//   EN        in  1     clock enable (0 freezes state, suppresses loads)
//   instr     in  8     ROM word at rom_addr ([7:4] opcode, [3:0] immediate)
//   alu_carry in  1     ALU adder carry-out for the current instruction
//   rom_addr  out PC_W  current program counter
//   im        out 4     immediate field
//   sel       out 2     ALU mux select
//   load_a    out 1     load strobe for register A
//   load_b    out 1     load strobe for register B
//   load_out  out 1     load strobe for the OUT register
//   carry     out 1     registered carry flag
//   halted    out 1     sticky jump-to-self indicator
module td4_control_unit
  import td4_pkg::*;
#(
  parameter int unsigned     PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            EN,
  input  logic [7:0]      instr,
  input  logic            alu_carry,
  output logic [PC_W-1:0] rom_addr,
  output logic [3:0]      im,
  output logic [1:0]      sel,
  output logic            load_a,
  output logic            load_b,
  output logic            load_out,
  output logic            carry,
  output logic            halted
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;
  logic            dec_load_a;
  logic            dec_load_b;
  logic            dec_load_out;
  logic            pc_load;
  logic            active;

  td4_decoder u_decoder (
    .opcode   (instr[OPC_MSB:OPC_LSB]),
    .carry    (carry),
    .sel      (sel),
    .load_a   (dec_load_a),
    .load_b   (dec_load_b),
    .load_out (dec_load_out),
    .pc_load  (pc_load)
  );

  assign im       = instr[IM_MSB:IM_LSB];
  assign target   = PC_W'(im);
  assign rom_addr = pc;

  // Strobes are qualified by reset as well as enable so that downstream
  // registers never load while the unit is held in reset.
  assign active   = EN & CLR;
  assign load_a   = dec_load_a   & active;
  assign load_b   = dec_load_b   & active;
  assign load_out = dec_load_out & active;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pc     <= RESET_PC;
      carry  <= 1'b0;
      halted <= 1'b0;
    end else if (EN) begin
      carry <= alu_carry;
      if (pc_load) begin
        pc <= target;
        if (target == pc) begin
          halted <= 1'b1;
        end
      end else begin
        pc <= pc + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_td4_control_unit.sv
// Self-checking bench for td4_control_unit: table-driven decode vectors,
// hand-written multi-cycle sequences, and randomized stimulus against a
// behavioural model of the TD4 sequencing rules.
module tb_td4_control_unit;

  logic       CLK;
  logic       CLR;
  logic       EN;
  logic [7:0] instr;
  logic       alu_carry;
  logic [3:0] rom_addr;
  logic [3:0] im;
  logic [1:0] sel;
  logic       load_a;
  logic       load_b;
  logic       load_out;
  logic       carry;
  logic       halted;

  td4_control_unit #(
    .PC_W     (4),
    .RESET_PC (4'd0)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .EN        (EN),
    .instr     (instr),
    .alu_carry (alu_carry),
    .rom_addr  (rom_addr),
    .im        (im),
    .sel       (sel),
    .load_a    (load_a),
    .load_b    (load_b),
    .load_out  (load_out),
    .carry     (carry),
    .halted    (halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  int m_pc     = 0;
  int m_carry  = 0;
  int m_halted = 0;

  // Opcode behaviour tables: mux select and destination (0 none, 1 A, 2 B, 3 OUT).
  int sel_tab  [16];
  int dest_tab [16];

  typedef struct {
    logic [7:0] instr;
    logic [1:0] sel;
    logic       la;
    logic       lb;
    logic       lo;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int op;
    int dst;
    bit act;
    op  = int'(instr[7:4]);
    dst = dest_tab[op];
    act = (CLR === 1'b1) && (EN === 1'b1);
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("carry",    32'(carry),    32'(m_carry));
    chk("halted",   32'(halted),   32'(m_halted));
    chk("im",       32'(im),       32'(instr[3:0]));
    chk("sel",      32'(sel),      32'(sel_tab[op]));
    chk("load_a",   32'(load_a),   32'(act && dst == 1));
    chk("load_b",   32'(load_b),   32'(act && dst == 2));
    chk("load_out", 32'(load_out), 32'(act && dst == 3));
  endtask

  task automatic apply(input logic [7:0] i, input logic e, input logic c);
    instr     = i;
    EN        = e;
    alu_carry = c;
    #1;
  endtask

  // Advance the model over the coming edge, then wait for it.
  task automatic step();
    int op;
    int imm;
    bit taken;
    if (CLR === 1'b1 && EN === 1'b1) begin
      op    = int'(instr[7:4]);
      imm   = int'(instr[3:0]);
      taken = (op == 15) || (op == 14 && m_carry == 0);
      if (taken) begin
        if (imm == m_pc) m_halted = 1;
        m_pc = imm;
      end else begin
        m_pc = (m_pc + 1) % 16;
      end
      m_carry = int'(alu_carry);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cycle(input logic [7:0] i, input logic e, input logic c);
    apply(i, e, c);
    check_outputs();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pc_before;
    int carry_before;

    for (int k = 0; k < 16; k++) begin
      sel_tab[k]  = 3;
      dest_tab[k] = 0;
    end
    sel_tab[0]  = 0; dest_tab[0]  = 1;
    sel_tab[1]  = 1; dest_tab[1]  = 1;
    sel_tab[2]  = 2; dest_tab[2]  = 1;
    sel_tab[3]  = 3; dest_tab[3]  = 1;
    sel_tab[4]  = 0; dest_tab[4]  = 2;
    sel_tab[5]  = 1; dest_tab[5]  = 2;
    sel_tab[6]  = 2; dest_tab[6]  = 2;
    sel_tab[7]  = 3; dest_tab[7]  = 2;
    sel_tab[9]  = 1; dest_tab[9]  = 3;
    sel_tab[11] = 3; dest_tab[11] = 3;

    vt[0]  = '{8'h0A, 2'b00, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{8'h10, 2'b01, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{8'h20, 2'b10, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{8'h37, 2'b11, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{8'h40, 2'b00, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{8'h5C, 2'b01, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{8'h60, 2'b10, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{8'h7F, 2'b11, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{8'h91, 2'b01, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{8'hB6, 2'b11, 1'b0, 1'b0, 1'b1};
    vt[10] = '{8'h83, 2'b11, 1'b0, 1'b0, 1'b0};
    vt[11] = '{8'hA2, 2'b11, 1'b0, 1'b0, 1'b0};
    vt[12] = '{8'hC9, 2'b11, 1'b0, 1'b0, 1'b0};
    vt[13] = '{8'hD4, 2'b11, 1'b0, 1'b0, 1'b0};

    // Reset state, loads suppressed while CLR is low.
    CLR = 1'b0; EN = 1'b1; instr = 8'h00; alu_carry = 1'b1;
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_carry",    32'(carry),    32'd0);
    chk("reset_halted",   32'(halted),   32'd0);
    chk("reset_load_a",   32'(load_a),   32'd0);
    check_outputs();
    @(posedge CLK);
    #1;
    chk("reset_hold_rom_addr", 32'(rom_addr), 32'd0);
    CLR = 1'b1;

    // Sequential count with wrap, ADD A,0 each cycle.
    for (int i = 0; i < 17; i++) begin
      apply(8'h00, 1'b1, 1'b0);
      chk("count_rom_addr", 32'(rom_addr), 32'(i % 16));
      chk("count_load_a",   32'(load_a),   32'd1);
      chk("count_sel",      32'(sel),      32'd0);
      check_outputs();
      step();
    end

    // Decode table.
    for (int v = 0; v < 14; v++) begin
      apply(vt[v].instr, 1'b1, 1'($urandom_range(0, 1)));
      pc_before = m_pc;
      chk("tbl_sel",      32'(sel),      32'(vt[v].sel));
      chk("tbl_load_a",   32'(load_a),   32'(vt[v].la));
      chk("tbl_load_b",   32'(load_b),   32'(vt[v].lb));
      chk("tbl_load_out", 32'(load_out), 32'(vt[v].lo));
      chk("tbl_im",       32'(im),       32'(vt[v].instr[3:0]));
      check_outputs();
      step();
      chk("tbl_pc_inc", 32'(rom_addr), 32'((pc_before + 1) % 16));
    end

    // JNC with carry set: falls through. With carry clear: jumps.
    cycle(8'h00, 1'b1, 1'b1);
    pc_before = m_pc;
    cycle(8'hE5, 1'b1, 1'b0);
    chk("jnc_not_taken", 32'(rom_addr), 32'((pc_before + 1) % 16));
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'hE5, 1'b1, 1'b0);
    chk("jnc_taken", 32'(rom_addr), 32'd5);

    // EN low freezes state and suppresses loads.
    cycle(8'h00, 1'b1, 1'b1);
    pc_before    = m_pc;
    carry_before = m_carry;
    for (int i = 0; i < 3; i++) begin
      apply(8'h91, 1'b0, 1'($urandom_range(0, 1)));
      chk("en0_load_out", 32'(load_out), 32'd0);
      chk("en0_sel",      32'(sel),      32'd1);
      check_outputs();
      step();
      chk("en0_rom_addr", 32'(rom_addr), 32'(pc_before));
      chk("en0_carry",    32'(carry),    32'(carry_before));
    end
    apply(8'h91, 1'b1, 1'b0);
    chk("en1_load_out", 32'(load_out), 32'd1);
    check_outputs();
    step();
    chk("en1_rom_addr", 32'(rom_addr), 32'((pc_before + 1) % 16));

    // Jump-to-self halts; halted is sticky.
    cycle(8'hF3, 1'b1, 1'b0);
    chk("halt_pre", 32'(halted), 32'd0);
    cycle(8'hF3, 1'b1, 1'b0);
    chk("halt_set",  32'(halted),   32'd1);
    chk("halt_addr", 32'(rom_addr), 32'd3);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'hF8, 1'b1, 1'b0);
    chk("halt_sticky", 32'(halted), 32'd1);

    // Reach PC=9 with carry=1, then pulse CLR low mid-cycle.
    cycle(8'h00, 1'b1, 1'b1);
    chk("pre_reset_pc",    32'(rom_addr), 32'd9);
    chk("pre_reset_carry", 32'(carry),    32'd1);
    apply(8'h37, 1'b1, 1'b1);
    #2;
    CLR = 1'b0;
    #1;
    m_pc = 0; m_carry = 0; m_halted = 0;
    chk("async_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_carry",    32'(carry),    32'd0);
    chk("async_halted",   32'(halted),   32'd0);
    chk("async_load_a",   32'(load_a),   32'd0);
    check_outputs();
    @(posedge CLK);
    #1;
    check_outputs();
    CLR = 1'b1;
    cycle(8'h00, 1'b1, 1'b0);
    chk("post_reset_pc", 32'(rom_addr), 32'd1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
